// File: rtl/spi_burst_master.sv
// SPI burst master with a Wishbone register interface and small TX/RX byte FIFOs.
// Bytes queued in TX are shifted MSB first; back-to-back bytes keep CS low.
module spi_burst_master #(
  parameter int unsigned NUM_CS     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [2:0]        wb_adr_i,
  input  logic [7:0]        wb_dat_i,
  output logic [7:0]        wb_dat_o,
  output logic              wb_ack_o,
  output logic              inta_o,
  output logic              sck_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] ncs_o
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CsW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StNext, StEnd} state_e;

  // Register file and bus state
  logic                 ack_q, ack_d;
  logic [7:0]           dat_q, dat_d;
  logic [4:0]           ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CsW-1:0]       cssel_q, cssel_d;
  logic                 txovf_q, txovf_d, rxovf_q, rxovf_d, done_q, done_d;
  logic                 inta_q;

  // FSM and shifter state
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           edge_q, edge_d;
  logic                 phase_q, phase_d;
  logic [7:0]           sh_q, sh_d, rsh_q, rsh_d;
  logic                 mosi_q, mosi_d;
  logic [NUM_CS-1:0]    ncs_q, ncs_d;

  // FIFOs
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [AW:0]   tx_cnt_q, rx_cnt_q;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop, rx_store, done_set;
  logic [7:0]    tx_head, rx_head, status;

  logic req, wr_req, rd_req, wr_ctrl, wr_status, wr_data, rd_data, wr_div, wr_cssel;
  logic en, cpol, cpha, cs_hold, ie, busy, tick;

  assign en      = ctrl_q[0];
  assign cpol    = ctrl_q[1];
  assign cpha    = ctrl_q[2];
  assign cs_hold = ctrl_q[3];
  assign ie      = ctrl_q[4];
  assign busy    = (state_q != StIdle);
  assign tick    = (cnt_q == div_q);

  // A new access is accepted only while ack is low, giving one wait state and no back-to-back acks
  assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_req    = req & wb_we_i;
  assign rd_req    = req & ~wb_we_i;
  assign wr_ctrl   = wr_req & (wb_adr_i == 3'd0);
  assign wr_status = wr_req & (wb_adr_i == 3'd1);
  assign wr_data   = wr_req & (wb_adr_i == 3'd2);
  assign wr_div    = wr_req & (wb_adr_i == 3'd3);
  assign wr_cssel  = wr_req & (wb_adr_i == 3'd4);
  assign rd_data   = rd_req & (wb_adr_i == 3'd2);

  assign tx_full  = (tx_cnt_q == (AW+1)'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (AW+1)'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_head  = tx_mem[tx_rp_q];
  assign rx_head  = rx_mem[rx_rp_q];
  assign tx_push  = wr_data & ~tx_full;
  assign rx_push  = rx_store & ~rx_full;
  assign rx_pop   = rd_data & ~rx_empty;

  assign status = {done_q, txovf_q, rxovf_q, rx_empty, rx_full, tx_empty, tx_full, busy};

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign inta_o   = inta_q;
  assign sck_o    = cpol ^ phase_q;
  assign mosi_o   = mosi_q;
  assign ncs_o    = ncs_q;

  // Register writes, read mux and sticky status flags
  always_comb begin
    ack_d   = req;
    dat_d   = dat_q;
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    cssel_d = cssel_q;
    if (wr_ctrl) begin
      // Timing-related fields are frozen while a transfer is in flight
      ctrl_d = busy ? {wb_dat_i[4:3], ctrl_q[2:1], wb_dat_i[0]} : wb_dat_i[4:0];
    end
    if (wr_div && !busy)   div_d   = DIV_WIDTH'(wb_dat_i);
    if (wr_cssel && !busy) cssel_d = wb_dat_i[CsW-1:0];
    if (rd_req) begin
      unique case (wb_adr_i)
        3'd0:    dat_d = {3'b000, ctrl_q};
        3'd1:    dat_d = status;
        3'd2:    dat_d = rx_empty ? 8'h00 : rx_head;
        3'd3:    dat_d = 8'(div_q);
        3'd4:    dat_d = 8'(cssel_q);
        default: dat_d = 8'h00;
      endcase
    end
    // Set wins over write-one-to-clear in the same cycle
    txovf_d = (txovf_q & ~(wr_status & wb_dat_i[6])) | (wr_data & tx_full);
    rxovf_d = (rxovf_q & ~(wr_status & wb_dat_i[5])) | (rx_store & rx_full);
    done_d  = (done_q & ~(wr_status & wb_dat_i[7])) | done_set;
  end

  // Bus-side registers, FIFO pointers and interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      ctrl_q   <= '0;
      div_q    <= '0;
      cssel_q  <= '0;
      txovf_q  <= 1'b0;
      rxovf_q  <= 1'b0;
      done_q   <= 1'b0;
      inta_q   <= 1'b0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      cssel_q  <= cssel_d;
      txovf_q  <= txovf_d;
      rxovf_q  <= rxovf_d;
      done_q   <= done_d;
      inta_q   <= ie & done_q;
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      rx_cnt_q <= rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wp_q] <= wb_dat_i;
    if (rx_push) rx_mem[rx_wp_q] <= rsh_q;
  end

  // Transfer FSM: next state, shifter and chip-select control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    phase_d  = phase_q;
    sh_d     = sh_q;
    rsh_d    = rsh_q;
    mosi_d   = mosi_q;
    ncs_d    = ncs_q;
    tx_pop   = 1'b0;
    rx_store = 1'b0;
    done_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        phase_d = 1'b0;
        if (!cs_hold) ncs_d = '1;
        if (en && !tx_empty) begin
          tx_pop  = 1'b1;
          sh_d    = tx_head;
          mosi_d  = tx_head[7];
          ncs_d   = ~(NUM_CS'(1) << cssel_q);
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (tick) begin
          cnt_d   = '0;
          edge_d  = 4'd0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (tick) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          edge_d  = edge_q + 4'd1;
          // Even edges are leading; CPHA selects which parity samples
          if (edge_q[0] == cpha) begin
            rsh_d = {rsh_q[6:0], miso_i};
          end else if (cpha) begin
            mosi_d = sh_q[7];
            sh_d   = {sh_q[6:0], 1'b0};
          end else begin
            mosi_d = sh_q[6];
            sh_d   = {sh_q[6:0], 1'b0};
          end
          if (edge_q == 4'd15) state_d = StNext;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNext: begin
        rx_store = 1'b1;
        cnt_d    = '0;
        if (en && !tx_empty) begin
          tx_pop  = 1'b1;
          sh_d    = tx_head;
          mosi_d  = tx_head[7];
          edge_d  = 4'd0;
          state_d = StShift;
        end else if (cs_hold) begin
          done_set = 1'b1;
          state_d  = StIdle;
        end else begin
          state_d = StEnd;
        end
      end
      StEnd: begin
        if (tick) begin
          ncs_d    = '1;
          done_set = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      edge_q  <= 4'd0;
      phase_q <= 1'b0;
      sh_q    <= 8'h00;
      rsh_q   <= 8'h00;
      mosi_q  <= 1'b0;
      ncs_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      rsh_q   <= rsh_d;
      mosi_q  <= mosi_d;
      ncs_q   <= ncs_d;
    end
  end

endmodule

// File: tb/tb_spi_burst_master.sv
// Directed and randomized bench for spi_burst_master with MISO looped back to MOSI.
// An SPI slave monitor reconstructs the bytes seen on the wire from the mode rules.
module tb_spi_burst_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0] adr = 3'd0;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       ack, inta, sck, mosi;
  logic [1:0] ncs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_burst_master #(.NUM_CS(2), .FIFO_DEPTH(4), .DIV_WIDTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack), .inta_o(inta),
    .sck_o(sck), .mosi_o(mosi), .miso_i(mosi), .ncs_o(ncs)
  );

  // Slave-side monitor
  logic       cpol_m = 1'b0, cpha_m = 1'b0;
  logic       sck_prev = 1'b0, lead;
  logic [7:0] mon_byte = 8'h00;
  int         mon_bits = 0, lead_n = 0, last_lead = 0, cyc_n = 0;
  int         per_min = 1000000, per_max = 0;
  logic [7:0] mon_q[$];
  logic [1:0] cs_seen = 2'b11;
  logic       cs_multi = 1'b0, cs_track = 1'b0, cs_rose = 1'b0;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (rst) begin
      mon_bits = 0;
      lead_n   = 0;
    end else if (ncs != 2'b11) begin
      cs_seen = ncs;
      if (sck != sck_prev) begin
        lead = (sck != cpol_m);
        if (lead) begin
          if (lead_n % 8 != 0) begin
            if (cyc_n - last_lead < per_min) per_min = cyc_n - last_lead;
            if (cyc_n - last_lead > per_max) per_max = cyc_n - last_lead;
          end
          last_lead = cyc_n;
          lead_n++;
        end
        if (lead != cpha_m) begin
          mon_byte = {mon_byte[6:0], mosi};
          mon_bits++;
          if (mon_bits == 8) begin
            mon_q.push_back(mon_byte);
            mon_bits = 0;
          end
        end
      end
    end
    sck_prev = sck;
    if ($countones(~ncs) > 1) cs_multi = 1'b1;
    if (cs_track && ncs[0]) cs_rose = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic w, input logic [2:0] a, input logic [7:0] d,
                    output logic [7:0] q);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 16);
    check("wb_ack", ack, 1'b1);
    check("wb_wait", n, 1);
    q = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("wb_ack_pulse", ack, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb(1'b1, a, d, q);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] q;
    wb(1'b0, a, 8'h00, q);
    check(tag, q, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] s;
    int n;
    n = 0;
    do begin
      wb(1'b0, 3'd1, 8'h00, s);
      n++;
    end while (s[0] && n < 400);
    check(tag, s[0], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    mon_q.delete();
    per_min = 1000000;
    per_max = 0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] sent[$];
    logic [7:0] b, st;
    logic [1:0] exp_cs;
    int n, nrx, sel;

    // Reset state and register map
    do_reset();
    #1;
    check("rst_ncs", ncs, 2'b11);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_dat", dat_o, 8'h00);
    check("rst_inta", inta, 1'b0);
    rd_chk("rst_ctrl", 3'd0, 8'h00);
    rd_chk("rst_status", 3'd1, 8'h14);
    rd_chk("rst_div", 3'd3, 8'h00);
    rd_chk("rst_cssel", 3'd4, 8'h00);
    rd_chk("rst_rx_empty", 3'd2, 8'h00);
    wr(3'd5, 8'hFF);
    rd_chk("reg5_zero", 3'd5, 8'h00);

    // Mode 0, DIV=1, CS1: two-byte burst
    cpol_m = 1'b0; cpha_m = 1'b0;
    wr(3'd3, 8'h01);
    wr(3'd4, 8'h01);
    wr(3'd2, 8'h0B);
    wr(3'd2, 8'h00);
    wr(3'd0, 8'h01);
    wait_idle("t1_idle");
    check("t1_cs", cs_seen, 2'b01);
    check("t1_ncs_after", ncs, 2'b11);
    check("t1_per_min", per_min, 4);
    check("t1_per_max", per_max, 4);
    check("t1_mon_n", mon_q.size(), 2);
    if (mon_q.size() == 2) begin
      check("t1_mosi0", mon_q[0], 8'h0B);
      check("t1_mosi1", mon_q[1], 8'h00);
    end
    rd_chk("t1_status", 3'd1, 8'h84);
    rd_chk("t1_rx0", 3'd2, 8'h0B);
    rd_chk("t1_rx1", 3'd2, 8'h00);

    // CPOL=1 CPHA=1 loopback with interrupt
    do_reset();
    cpol_m = 1'b1; cpha_m = 1'b1;
    wr(3'd0, 8'h16);
    check("t2_sck_idle", sck, 1'b1);
    wr(3'd2, 8'hA5);
    wr(3'd0, 8'h17);
    wait_idle("t2_idle");
    check("t2_sck_after", sck, 1'b1);
    check("t2_inta", inta, 1'b1);
    rd_chk("t2_status", 3'd1, 8'h84);
    rd_chk("t2_rx", 3'd2, 8'hA5);
    check("t2_mon_n", mon_q.size(), 1);
    if (mon_q.size() == 1) check("t2_mosi", mon_q[0], 8'hA5);
    wr(3'd1, 8'h80);
    @(posedge clk); #1;
    check("t2_inta_clr", inta, 1'b0);

    // TX overflow with EN=0, then drain
    do_reset();
    cpol_m = 1'b0; cpha_m = 1'b0;
    sent.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      wr(3'd2, b);
    end
    rd_chk("t3_status_full", 3'd1, 8'h52);
    wr(3'd0, 8'h01);
    wr(3'd3, 8'h07);
    wait_idle("t3_idle");
    rd_chk("t3_div_frozen", 3'd3, 8'h00);
    check("t3_mon_n", mon_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < mon_q.size()) check("t3_mosi", mon_q[i], sent[i]);
      rd_chk("t3_rx", 3'd2, sent[i]);
    end

    // CS_HOLD keeps CS low across separate bytes
    do_reset();
    wr(3'd0, 8'h09);
    wr(3'd2, 8'h3C);
    wait_idle("t4_idle0");
    check("t4_cs_held", ncs, 2'b10);
    cs_rose = 1'b0;
    cs_track = 1'b1;
    repeat (10) @(posedge clk);
    wr(3'd2, 8'hC3);
    wait_idle("t4_idle1");
    cs_track = 1'b0;
    check("t4_cs_cont", cs_rose, 1'b0);
    check("t4_cs_held2", ncs, 2'b10);
    rd_chk("t4_status", 3'd1, 8'h84);
    wr(3'd0, 8'h01);
    check("t4_cs_release", ncs, 2'b11);
    check("t4_mon_n", mon_q.size(), 2);

    // Randomized modes, dividers, chip selects and burst lengths against the model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      cpol_m = 1'($urandom);
      cpha_m = 1'($urandom);
      sel    = int'($urandom_range(0, 1));
      n      = int'($urandom_range(2, 6));
      sent.delete();
      wr(3'd3, 8'($urandom_range(0, 2)));
      wr(3'd4, 8'(sel));
      wr(3'd0, {5'b0, cpha_m, cpol_m, 1'b0});
      for (int i = 0; i < n && i < 4; i++) begin
        b = 8'($urandom);
        sent.push_back(b);
        wr(3'd2, b);
      end
      wr(3'd0, {5'b0, cpha_m, cpol_m, 1'b1});
      wait_idle("rnd_idle");
      for (int i = 4; i < n; i++) begin
        b = 8'($urandom);
        sent.push_back(b);
        wr(3'd2, b);
        wait_idle("rnd_idle_tail");
      end
      exp_cs = 2'b11;
      exp_cs[sel] = 1'b0;
      check("rnd_cs", cs_seen, exp_cs);
      check("rnd_sck_idle", sck, cpol_m);
      st = 8'h84;
      if (n >= 4) st = st | 8'h08;
      if (n > 4)  st = st | 8'h20;
      rd_chk("rnd_status", 3'd1, st);
      check("rnd_mon_n", mon_q.size(), n);
      for (int i = 0; i < n && i < mon_q.size(); i++) check("rnd_mosi", mon_q[i], sent[i]);
      nrx = (n > 4) ? 4 : n;
      for (int i = 0; i < nrx; i++) rd_chk("rnd_rx", 3'd2, sent[i]);
      rd_chk("rnd_rx_empty", 3'd2, 8'h00);
    end

    // Reset in the middle of a byte
    do_reset();
    cpol_m = 1'b0; cpha_m = 1'b0;
    wr(3'd3, 8'h03);
    wr(3'd2, 8'h3C);
    wr(3'd0, 8'h01);
    n = 0;
    while (mon_bits != 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("t6_reach_bit3", mon_bits, 3);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t6_ncs", ncs, 2'b11);
    check("t6_sck", sck, 1'b0);
    check("t6_mosi", mosi, 1'b0);
    check("t6_ack", ack, 1'b0);
    check("t6_dat", dat_o, 8'h00);
    check("t6_inta", inta, 1'b0);
    @(negedge clk); rst = 1'b0;
    rd_chk("t6_status", 3'd1, 8'h14);
    rd_chk("t6_rx_empty", 3'd2, 8'h00);

    check("cs_onehot", cs_multi, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
